// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the frame-granular FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2
  } arb_state_e;

  // Idle cycles after a frame so fifo_free catches up with the last beat.
  localparam int SETTLE_CYCLES = 2;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter; master is the arbiter side.
interface fifo_write_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16
);

  localparam int LEN_BITS = $clog2(DEPTH) + 1;

  logic [NUM_PORTS-1:0]          req;
  logic [NUM_PORTS*LEN_BITS-1:0] req_len;
  logic [NUM_PORTS-1:0]          grant;
  logic [NUM_PORTS-1:0]          in_en;
  logic [NUM_PORTS*WIDTH-1:0]    in_data;
  logic [LEN_BITS-1:0]           fifo_free;
  logic                          fifo_wr_en;
  logic [WIDTH-1:0]              fifo_wr_data;
  logic                          busy;
  logic                          timeout;

  modport master (
    input  req, req_len, in_en, in_data, fifo_free,
    output grant, fifo_wr_en, fifo_wr_data, busy, timeout
  );

  modport slave (
    output req, req_len, in_en, in_data, fifo_free,
    input  grant, fifo_wr_en, fifo_wr_data, busy, timeout
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible port at or after rr_ptr, with wrap.
module rr_priority_picker #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] winner,
  output logic                 found
);

  logic [PTR_W-1:0] idx_s;

  // Rotating scan; the first hit latches found and masks later candidates.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx_s  = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      idx_s = PTR_W'((32'(rr_ptr) + 32'(off)) % 32'(NUM_PORTS));
      if (!found && eligible[idx_s]) begin
        winner[idx_s] = 1'b1;
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, frame-granular arbiter for a shared FIFO write port.
// Optional stall watchdog enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_write_arbiter_if.master bus
);

  localparam int LEN_BITS = $clog2(DEPTH) + 1;
  localparam int PTR_W    = $clog2(NUM_PORTS);
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
    $error("fifo_write_arbiter: NUM_PORTS must be 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_write_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e           state_r, state_n;
  logic [NUM_PORTS-1:0] grant_r, grant_n;
  logic [NUM_PORTS-1:0] elig_s, win_s;
  logic                 found_s;
  logic [PTR_W-1:0]     rr_ptr_r, rr_ptr_n;
  logic [PTR_W-1:0]     g_idx_r, g_idx_n;
  logic [PTR_W-1:0]     win_idx_s;
  logic [LEN_BITS-1:0]  len_q_r, len_q_n;
  logic [LEN_BITS-1:0]  cnt_r, cnt_n;
  logic [LEN_BITS-1:0]  port_len_s;
  logic [SETTLE_W-1:0]  settle_r, settle_n;
  logic                 wr_en_r, wr_en_n;
  logic [WIDTH-1:0]     wr_data_r, wr_data_n;
  logic [WIDTH-1:0]     g_data_s;
  logic                 timeout_r, timeout_n;
  logic                 beat_s;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_r, stall_n;
`endif

  // Eligibility: a valid frame length that fits in the FIFO's free space.
  always_comb begin
    elig_s     = '0;
    port_len_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_len_s = bus.req_len[i*LEN_BITS +: LEN_BITS];
      elig_s[i]  = bus.req[i]
                   && (port_len_s != LEN_BITS'(0))
                   && (port_len_s <= LEN_BITS'(DEPTH))
                   && (port_len_s <= bus.fifo_free);
    end
  end

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .eligible (elig_s),
    .rr_ptr   (rr_ptr_r),
    .winner   (win_s),
    .found    (found_s)
  );

  // One-hot winner to binary index for the data mux and pointer update.
  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_s[i]) begin
        win_idx_s = PTR_W'(i);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  assign beat_s   = (state_r == GRANT) && bus.in_en[g_idx_r];
  assign g_data_s = bus.in_data[g_idx_r*WIDTH +: WIDTH];

  // Next-state, grant, beat counter and output-register inputs.
  always_comb begin
    state_n   = state_r;
    grant_n   = grant_r;
    rr_ptr_n  = rr_ptr_r;
    g_idx_n   = g_idx_r;
    len_q_n   = len_q_r;
    cnt_n     = cnt_r;
    settle_n  = settle_r;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data_r;
    timeout_n = 1'b0;
`ifdef FIFO_ARB_TIMEOUT_EN
    stall_n   = stall_r;
`endif
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_n  = GRANT;
          grant_n  = win_s;
          g_idx_n  = win_idx_s;
          len_q_n  = bus.req_len[win_idx_s*LEN_BITS +: LEN_BITS];
          cnt_n    = '0;
          rr_ptr_n = (win_idx_s == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx_s + PTR_W'(1);
`ifdef FIFO_ARB_TIMEOUT_EN
          stall_n  = '0;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (beat_s) begin
          wr_en_n   = 1'b1;
          wr_data_n = g_data_s;
          cnt_n     = cnt_r + LEN_BITS'(1);
`ifdef FIFO_ARB_TIMEOUT_EN
          stall_n   = '0;
`endif
          if (cnt_r == len_q_r - LEN_BITS'(1)) begin
            state_n  = SETTLE;
            grant_n  = '0;
            settle_n = '0;
          end else begin
            state_n = GRANT;
          end
        end else begin
`ifdef FIFO_ARB_TIMEOUT_EN
          // Abort on the TIMEOUT-th consecutive idle cycle; no padding of the frame.
          if (stall_r == STALL_W'(TIMEOUT - 1)) begin
            timeout_n = 1'b1;
            grant_n   = '0;
            state_n   = SETTLE;
            settle_n  = '0;
            stall_n   = '0;
          end else begin
            stall_n = stall_r + STALL_W'(1);
          end
`else
          state_n = GRANT;
`endif
        end
      end
      SETTLE: begin
        if (settle_r == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_n = IDLE;
        end else begin
          settle_n = settle_r + SETTLE_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  // State, datapath and output registers; reset clears all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      rr_ptr_r  <= '0;
      g_idx_r   <= '0;
      len_q_r   <= '0;
      cnt_r     <= '0;
      settle_r  <= '0;
      wr_en_r   <= 1'b0;
      wr_data_r <= '0;
      timeout_r <= 1'b0;
`ifdef FIFO_ARB_TIMEOUT_EN
      stall_r   <= '0;
`endif
    end else begin
      state_r   <= state_n;
      grant_r   <= grant_n;
      rr_ptr_r  <= rr_ptr_n;
      g_idx_r   <= g_idx_n;
      len_q_r   <= len_q_n;
      cnt_r     <= cnt_n;
      settle_r  <= settle_n;
      wr_en_r   <= wr_en_n;
      wr_data_r <= wr_data_n;
      timeout_r <= timeout_n;
`ifdef FIFO_ARB_TIMEOUT_EN
      stall_r   <= stall_n;
`endif
    end
  end

  assign bus.grant        = grant_r;
  assign bus.fifo_wr_en   = wr_en_r;
  assign bus.fifo_wr_data = wr_data_r;
  assign bus.busy         = (state_r != IDLE);
  assign bus.timeout      = timeout_r;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed/randomized bench for fifo_write_arbiter against a frame-level reference model.
module tb_fifo_write_arbiter;

  localparam int NP = 4;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int LB = $clog2(D) + 1;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_PORTS(NP), .WIDTH(W), .DEPTH(D)) bus ();

  fifo_write_arbiter #(
    .NUM_PORTS (NP),
    .WIDTH     (W),
    .DEPTH     (D),
    .TIMEOUT   (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: requests, lengths, free space and round-robin pointer.
  int m_ptr;
  int m_req [NP];
  int m_len [NP];
  int m_free;

  int p;
  int seen;
  int pulses;
  int extra;
  int bad;
  logic [W-1:0] d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NP; i++) begin
      bus.req[i]               = (m_req[i] != 0);
      bus.req_len[i*LB +: LB]  = LB'(m_len[i]);
    end
    bus.fifo_free = LB'(m_free);
  endtask

  task automatic quiet();
    bus.in_en   = '0;
    bus.in_data = '0;
  endtask

  // First eligible port at or after the pointer, wrapping; -1 when none.
  function automatic int m_pick();
    for (int off = 0; off < NP; off++) begin
      int q;
      q = (m_ptr + off) % NP;
      if (m_req[q] != 0 && m_len[q] >= 1 && m_len[q] <= D && m_len[q] <= m_free) return q;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    for (int i = 0; i < NP; i++) begin
      m_req[i] = 0;
      m_len[i] = 0;
    end
    m_free = D;
    m_ptr  = 0;
    apply();
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_wr_data", bus.fifo_wr_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout, 0);
    rst = 1'b0;
  endtask

  // One IDLE evaluation: grant must appear on the next cycle iff the model finds a winner.
  task automatic arbitrate(output int pk);
    pk = m_pick();
    apply();
    @(negedge clk);
    chk("gap_wr_en", bus.fifo_wr_en, 0);
    if (pk >= 0) begin
      chk("grant", bus.grant, 32'(1) << pk);
      m_ptr = (pk + 1) % NP;
    end else begin
      chk("no_grant", bus.grant, 0);
      chk("idle_busy", bus.busy, 0);
    end
  endtask

  task automatic drive_beat(input int gp, input int en, output logic [W-1:0] dv);
    dv = W'($urandom);
    for (int q = 0; q < NP; q++) begin
      if (q == gp) begin
        bus.in_en[q]          = 1'(en);
        bus.in_data[q*W +: W] = dv;
      end else begin
        bus.in_en[q]          = 1'($urandom_range(1, 0));
        bus.in_data[q*W +: W] = W'($urandom);
      end
    end
  endtask

  // Continuous frame from port gp: every beat lands one cycle later, then 2 settle cycles.
  task automatic stream(input int gp, input int len);
    logic [W-1:0] dv;
    for (int b = 0; b < len; b++) begin
      drive_beat(gp, 1, dv);
      @(negedge clk);
      chk("beat_wr_en", bus.fifo_wr_en, 1);
      chk("beat_data", bus.fifo_wr_data, dv);
      chk("frame_grant", bus.grant, (b == len - 1) ? 32'(0) : (32'(1) << gp));
      chk("frame_busy", bus.busy, 1);
    end
    quiet();
    @(negedge clk);
    chk("settle2_busy", bus.busy, 1);
    chk("settle2_wr_en", bus.fifo_wr_en, 0);
    @(negedge clk);
    chk("idle_busy_after", bus.busy, 0);
    chk("idle_wr_en_after", bus.fifo_wr_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    do_reset();

    // Single frame, port 2, length 5.
    m_req[2] = 1; m_len[2] = 5;
    arbitrate(p);
    m_req[2] = 0; apply();
    if (p >= 0) stream(p, 5);

    // All four ports, length 3, from reset: strict rotation 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NP; i++) begin
      m_req[i] = 1; m_len[i] = 3;
    end
    for (int f = 0; f < 5; f++) begin
      arbitrate(p);
      if (p >= 0) stream(p, 3);
    end

    // Oversized frame waits for free space while a fitting one goes ahead.
    for (int i = 0; i < NP; i++) m_req[i] = 0;
    m_req[0] = 1; m_len[0] = 10;
    m_req[1] = 1; m_len[1] = 4;
    m_free   = 8;
    arbitrate(p);
    m_req[1] = 0; apply();
    if (p >= 0) stream(p, 4);
    for (int i = 0; i < 3; i++) arbitrate(p);
    m_free = 10;
    arbitrate(p);
    m_req[0] = 0; apply();
    if (p >= 0) stream(p, 10);

    // Illegal lengths never win; non-granted in_en noise never reaches the FIFO.
    m_free   = D;
    m_req[3] = 1; m_len[3] = 0;
    m_req[2] = 1; m_len[2] = 17;
    for (int i = 0; i < 6; i++) arbitrate(p);
    m_req[0] = 1; m_len[0] = 4;
    arbitrate(p);
    m_req[0] = 0; apply();
    if (p >= 0) stream(p, 4);
    m_req[2] = 0; m_req[3] = 0; apply();

    // Stalled requester: two beats of a length-6 frame, then nothing.
    m_req[1] = 1; m_len[1] = 6;
    arbitrate(p);
    m_req[1] = 0; apply();
    for (int b = 0; b < 2; b++) begin
      drive_beat(1, 1, d);
      @(negedge clk);
      chk("stall_beat_wr_en", bus.fifo_wr_en, 1);
      chk("stall_beat_data", bus.fifo_wr_data, d);
    end
    quiet();
`ifdef FIFO_ARB_TIMEOUT_EN
    seen = -1; pulses = 0; extra = 0;
    for (int j = 2; j <= 40; j++) begin
      @(negedge clk);
      if (bus.fifo_wr_en) extra++;
      if (bus.timeout) begin
        pulses++;
        if (seen < 0) seen = j;
        chk("timeout_grant", bus.grant, 0);
      end
    end
    chk("timeout_cycle", seen, TO + 1);
    chk("timeout_pulses", pulses, 1);
    chk("timeout_extra_words", extra, 0);
    chk("timeout_busy_end", bus.busy, 0);
`else
    bad = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (bus.grant !== 4'b0010 || bus.timeout !== 1'b0 || bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    chk("stall_hold_bad_cycles", bad, 0);
    chk("stall_grant_held", bus.grant, 4'b0010);
    chk("stall_no_timeout", bus.timeout, 0);
`endif

    // Reset during the third beat: outputs drop asynchronously, pointer returns to 0.
    do_reset();
    m_req[1] = 1; m_len[1] = 6;
    arbitrate(p);
    m_req[1] = 0; apply();
    for (int b = 0; b < 2; b++) begin
      drive_beat(1, 1, d);
      @(negedge clk);
      chk("pre_rst_data", bus.fifo_wr_data, d);
    end
    drive_beat(1, 1, d);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_grant", bus.grant, 0);
    chk("async_rst_wr_en", bus.fifo_wr_en, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_timeout", bus.timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    quiet();
    m_ptr = 0;
    m_req[0] = 1; m_len[0] = 2;
    m_req[1] = 1; m_len[1] = 2;
    arbitrate(p);
    chk("post_rst_port0_wins", bus.grant, 4'b0001);
    m_req[0] = 0; m_req[1] = 0; apply();
    if (p >= 0) stream(p, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
